// File: rtl/xbar_pkg.sv
// Shared defaults and grant encoding for the 2x2 valid/ready crossbar.
package xbar_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SEL_BIT = 4;

  // Which master currently owns a slave port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M1   = 2'd1,
    GNT_M2   = 2'd2
  } gnt_e;

  // The master that gets priority after the given one completes a beat.
  function automatic gnt_e other_master(gnt_e g);
    return (g == GNT_M2) ? GNT_M1 : GNT_M2;
  endfunction

endpackage

// File: rtl/xbar_arb_rr2.sv
// Two-requester round-robin arbiter for one slave port. Grant is combinational
// from requests; a stalled beat locks the grant until its handshake completes.
module xbar_arb_rr2
  import xbar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,        // bit0 = M1, bit1 = M2
  input  logic       valid_sel,  // valid currently presented to the slave
  input  logic       ready,      // slave ready
  output logic [1:0] gnt         // gnt_e encoding
);

  gnt_e lock_q, lock_d;
  gnt_e ptr_q,  ptr_d;
  gnt_e gnt_w;

  // Grant selection: a held lock wins, otherwise single requester, otherwise pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt_w = GNT_NONE;
    if (rst) begin
      gnt_w = GNT_NONE;
    end else if (lock_q != GNT_NONE) begin
      gnt_w = lock_q;
    end else begin
      case (req)
        2'b01:   gnt_w = GNT_M1;
        2'b10:   gnt_w = GNT_M2;
        2'b11:   gnt_w = ptr_q;
        default: gnt_w = GNT_NONE;
      endcase
    end
  end

  // Next arbitration state: handshake rotates priority, stall locks, anything else releases.
  always_comb begin
    lock_d = GNT_NONE;
    ptr_d  = ptr_q;
    if (valid_sel && ready) begin
      ptr_d = other_master(gnt_w);
    end else if (valid_sel) begin
      lock_d = gnt_w;
    end
  end

  // Arbitration state registers with synchronous reset to "M1 first, unlocked".
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      lock_q <= GNT_NONE;
      ptr_q  <= GNT_M1;
    end else begin
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
    end
  end

  assign gnt = gnt_w;

endmodule

// File: rtl/handshaking_xbar_2x2.sv
// 2-master x 2-slave valid/ready crossbar. Destination is chosen by one data
// bit; datapath and ready fan-back are purely combinational.
module handshaking_xbar_2x2
  import xbar_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_BIT = DEF_SEL_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_out_m1,
  input  logic              valid_out_m1,
  output logic              ready_in_m1,
  input  logic [DATA_W-1:0] data_out_m2,
  input  logic              valid_out_m2,
  output logic              ready_in_m2,
  output logic [DATA_W-1:0] data_in_s1,
  output logic              valid_in_s1,
  input  logic              ready_out_s1,
  output logic [DATA_W-1:0] data_in_s2,
  output logic              valid_in_s2,
  input  logic              ready_out_s2
);

  logic       req_m1_s1, req_m1_s2, req_m2_s1, req_m2_s2;
  logic [1:0] gnt_s1, gnt_s2;

  // Route each valid beat to exactly one slave using its select bit.
  always_comb begin
    req_m1_s1 = valid_out_m1 && !data_out_m1[SEL_BIT];
    req_m1_s2 = valid_out_m1 &&  data_out_m1[SEL_BIT];
    req_m2_s1 = valid_out_m2 && !data_out_m2[SEL_BIT];
    req_m2_s2 = valid_out_m2 &&  data_out_m2[SEL_BIT];
  end

  xbar_arb_rr2 u_arb_s1 (
    .clk       (clk),
    .rst       (rst),
    .req       ({req_m2_s1, req_m1_s1}),
    .valid_sel (valid_in_s1),
    .ready     (ready_out_s1),
    .gnt       (gnt_s1)
  );

  xbar_arb_rr2 u_arb_s2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({req_m2_s2, req_m1_s2}),
    .valid_sel (valid_in_s2),
    .ready     (ready_out_s2),
    .gnt       (gnt_s2)
  );

  // S1 path mux: granted master's routed valid and data, zero when ungranted.
  always_comb begin
    valid_in_s1 = 1'b0;
    data_in_s1  = '0;
    if (gnt_s1 == GNT_M1) begin
      valid_in_s1 = req_m1_s1;
      data_in_s1  = data_out_m1;
    end else if (gnt_s1 == GNT_M2) begin
      valid_in_s1 = req_m2_s1;
      data_in_s1  = data_out_m2;
    end
  end

  // S2 path mux: granted master's routed valid and data, zero when ungranted.
  always_comb begin
    valid_in_s2 = 1'b0;
    data_in_s2  = '0;
    if (gnt_s2 == GNT_M1) begin
      valid_in_s2 = req_m1_s2;
      data_in_s2  = data_out_m1;
    end else if (gnt_s2 == GNT_M2) begin
      valid_in_s2 = req_m2_s2;
      data_in_s2  = data_out_m2;
    end
  end

  // Ready fan-back: a master sees its decoded slave's ready only while granted there.
  always_comb begin
    ready_in_m1 = (req_m1_s1 && (gnt_s1 == GNT_M1) && ready_out_s1) ||
                  (req_m1_s2 && (gnt_s2 == GNT_M1) && ready_out_s2);
    ready_in_m2 = (req_m2_s1 && (gnt_s1 == GNT_M2) && ready_out_s1) ||
                  (req_m2_s2 && (gnt_s2 == GNT_M2) && ready_out_s2);
  end

endmodule

// File: tb/tb_handshaking_xbar_2x2.sv
// Self-checking bench for handshaking_xbar_2x2: directed vector table,
// hand-written lock/reset sequences, and randomized traffic against a model.
module tb_handshaking_xbar_2x2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_out_m1, data_out_m2;
  logic       valid_out_m1, valid_out_m2;
  logic       ready_in_m1, ready_in_m2;
  logic [7:0] data_in_s1, data_in_s2;
  logic       valid_in_s1, valid_in_s2;
  logic       ready_out_s1, ready_out_s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshaking_xbar_2x2 dut (
    .clk          (clk),
    .rst          (rst),
    .data_out_m1  (data_out_m1),
    .valid_out_m1 (valid_out_m1),
    .ready_in_m1  (ready_in_m1),
    .data_out_m2  (data_out_m2),
    .valid_out_m2 (valid_out_m2),
    .ready_in_m2  (ready_in_m2),
    .data_in_s1   (data_in_s1),
    .valid_in_s1  (valid_in_s1),
    .ready_out_s1 (ready_out_s1),
    .data_in_s2   (data_in_s2),
    .valid_in_s2  (valid_in_s2),
    .ready_out_s2 (ready_out_s2)
  );

  typedef struct {
    logic       r;
    logic [7:0] d1; logic v1;
    logic [7:0] d2; logic v2;
    logic       rs1, rs2;
    logic [7:0] eds1; logic evs1;
    logic [7:0] eds2; logic evs2;
    logic       erm1, erm2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle before sampling.
  task automatic apply(input logic r, input logic [7:0] d1, input logic v1,
                       input logic [7:0] d2, input logic v2,
                       input logic rs1, input logic rs2);
    @(negedge clk);
    rst = r;
    data_out_m1 = d1; valid_out_m1 = v1;
    data_out_m2 = d2; valid_out_m2 = v2;
    ready_out_s1 = rs1; ready_out_s2 = rs2;
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [7:0] eds1, input logic evs1,
                            input logic [7:0] eds2, input logic evs2,
                            input logic erm1, input logic erm2);
    check({tag, ".data_s1"},  32'(data_in_s1),  32'(eds1));
    check({tag, ".valid_s1"}, 32'(valid_in_s1), 32'(evs1));
    check({tag, ".data_s2"},  32'(data_in_s2),  32'(eds2));
    check({tag, ".valid_s2"}, 32'(valid_in_s2), 32'(evs2));
    check({tag, ".ready_m1"}, 32'(ready_in_m1), 32'(erm1));
    check({tag, ".ready_m2"}, 32'(ready_in_m2), 32'(erm2));
  endtask

  // Reference model: per slave, the owning master (-1 when free) and the
  // master that wins the next tie.
  int owner [2];
  int prio  [2];

  task automatic model_step(input logic r, input logic [7:0] d [2], input logic v [2],
                            input logic rs [2], input string tag,
                            output logic acc [2]);
    int   g [2];
    logic req [2][2];
    logic [7:0] eds [2];
    logic evs [2];
    logic erm [2];
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 2; m++)
        req[s][m] = v[m] && (int'(d[m][4]) == s);
    for (int s = 0; s < 2; s++) begin
      if (r)                            g[s] = -1;
      else if (owner[s] >= 0)           g[s] = owner[s];
      else if (req[s][0] && req[s][1])  g[s] = prio[s];
      else if (req[s][0])               g[s] = 0;
      else if (req[s][1])               g[s] = 1;
      else                              g[s] = -1;
      evs[s] = (g[s] >= 0) ? req[s][g[s]] : 1'b0;
      eds[s] = (g[s] >= 0) ? d[g[s]] : 8'h00;
    end
    for (int m = 0; m < 2; m++) begin
      int s;
      s = int'(d[m][4]);
      erm[m] = v[m] && (g[s] == m) && rs[s];
    end
    expect_out(tag, eds[0], evs[0], eds[1], evs[1], erm[0], erm[1]);
    for (int s = 0; s < 2; s++) begin
      if (r) begin
        owner[s] = -1; prio[s] = 0;
      end else if (evs[s] && rs[s]) begin
        owner[s] = -1; prio[s] = 1 - g[s];
      end else if (evs[s]) begin
        owner[s] = g[s];
      end else begin
        owner[s] = -1;
      end
    end
    acc[0] = erm[0];
    acc[1] = erm[1];
  endtask

  vec_t tbl [10];

  initial begin
    rst = 1'b1;
    data_out_m1 = '0; valid_out_m1 = 1'b0;
    data_out_m2 = '0; valid_out_m2 = 1'b0;
    ready_out_s1 = 1'b0; ready_out_s2 = 1'b0;

    //           r  d1     v1 d2     v2 rs1 rs2  eds1   evs1 eds2   evs2 erm1 erm2
    tbl[0] = '{1, 8'h20, 1, 8'h38, 1, 1, 1,   8'h00, 0,   8'h00, 0,   0,   0};
    tbl[1] = '{0, 8'h20, 1, 8'h00, 0, 1, 0,   8'h20, 1,   8'h00, 0,   1,   0};
    tbl[2] = '{0, 8'h30, 1, 8'h00, 0, 0, 0,   8'h00, 0,   8'h30, 1,   0,   0};
    tbl[3] = '{0, 8'h30, 1, 8'h00, 0, 0, 1,   8'h00, 0,   8'h30, 1,   1,   0};
    tbl[4] = '{0, 8'h20, 1, 8'h38, 1, 1, 1,   8'h20, 1,   8'h38, 1,   1,   1};
    tbl[5] = '{0, 8'h20, 1, 8'h38, 1, 1, 1,   8'h20, 1,   8'h38, 1,   1,   1};
    tbl[6] = '{1, 8'h20, 1, 8'h22, 1, 1, 0,   8'h00, 0,   8'h00, 0,   0,   0};
    tbl[7] = '{0, 8'h20, 1, 8'h22, 1, 1, 0,   8'h20, 1,   8'h00, 0,   1,   0};
    tbl[8] = '{0, 8'h20, 1, 8'h22, 1, 1, 0,   8'h22, 1,   8'h00, 0,   0,   1};
    tbl[9] = '{0, 8'h20, 1, 8'h22, 1, 1, 0,   8'h20, 1,   8'h00, 0,   1,   0};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].d1, tbl[i].v1, tbl[i].d2, tbl[i].v2, tbl[i].rs1, tbl[i].rs2);
      expect_out($sformatf("vec%0d", i), tbl[i].eds1, tbl[i].evs1, tbl[i].eds2,
                 tbl[i].evs2, tbl[i].erm1, tbl[i].erm2);
    end

    // Lock: M2 stalls on S1, M1 arrives, M2 keeps the grant until its handshake.
    apply(1, 8'h00, 0, 8'h00, 0, 0, 0); expect_out("lock_rst", 8'h00, 0, 8'h00, 0, 0, 0);
    apply(0, 8'h00, 0, 8'h22, 1, 0, 0); expect_out("lock_m2",  8'h22, 1, 8'h00, 0, 0, 0);
    apply(0, 8'h20, 1, 8'h22, 1, 0, 0); expect_out("lock_hold", 8'h22, 1, 8'h00, 0, 0, 0);
    apply(0, 8'h20, 1, 8'h22, 1, 1, 0); expect_out("lock_hs",  8'h22, 1, 8'h00, 0, 0, 1);
    apply(0, 8'h20, 1, 8'h00, 0, 1, 0); expect_out("lock_next", 8'h20, 1, 8'h00, 0, 1, 0);

    // Reset while M2 holds a lock on S1; M1 must win the first tie afterwards.
    apply(0, 8'h00, 0, 8'h22, 1, 0, 0); expect_out("rlock_m2", 8'h22, 1, 8'h00, 0, 0, 0);
    apply(1, 8'h20, 1, 8'h22, 1, 1, 0); expect_out("rlock_rst", 8'h00, 0, 8'h00, 0, 0, 0);
    apply(0, 8'h20, 1, 8'h22, 1, 1, 0); expect_out("rlock_tie", 8'h20, 1, 8'h00, 0, 1, 0);

    // Lock released by withdrawing valid: the other master gets S1 next cycle.
    apply(0, 8'h20, 1, 8'h00, 0, 0, 0); expect_out("drop_m1",  8'h20, 1, 8'h00, 0, 0, 0);
    apply(0, 8'h00, 0, 8'h22, 1, 0, 0); expect_out("drop_gap", 8'h00, 0, 8'h00, 0, 0, 0);
    apply(0, 8'h00, 0, 8'h22, 1, 1, 0); expect_out("drop_m2",  8'h22, 1, 8'h00, 0, 0, 1);

    // Randomized traffic: masters hold a beat until accepted, occasionally withdraw it.
    begin
      logic [7:0] d   [2];
      logic       v   [2];
      logic       rs  [2];
      logic       acc [2];
      logic       r;
      d = '{8'h00, 8'h00}; v = '{1'b0, 1'b0}; acc = '{1'b0, 1'b0};
      rs = '{1'b0, 1'b0};
      owner = '{-1, -1}; prio = '{0, 0};
      apply(1, 8'h00, 0, 8'h00, 0, 0, 0);
      model_step(1'b1, d, v, rs, "rand_init", acc);
      for (int i = 0; i < 600; i++) begin
        r = ($urandom_range(0, 63) == 0);
        for (int m = 0; m < 2; m++) begin
          if (!(v[m] && !acc[m]) || $urandom_range(0, 15) == 0) begin
            v[m] = ($urandom_range(0, 3) != 0);
            d[m] = 8'($urandom);
          end
          rs[m] = ($urandom_range(0, 2) != 0);
        end
        apply(r, d[0], v[0], d[1], v[1], rs[0], rs[1]);
        model_step(r, d, v, rs, $sformatf("rand%0d", i), acc);
        if (r) acc = '{1'b0, 1'b0};
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
